memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/arb_wait_counter.sv | 28 ++
 rtl/memory_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } arb_grant_t;

  localparam logic [15:0] ROM_LIMIT_DEFAULT = 16'h2000;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter with a zero flag; paces the strobe length of one access.
module arb_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             count_zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign count_zero = (count == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Shares memory_io between the fetch stage and the memory stage with fixed-length accesses.
// Optional feature: MEMORY_ARBITER_ROM_TRAP_EN rejects data writes below ROM_LIMIT without a bus cycle.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [15:0] ROM_LIMIT     = ROM_LIMIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_wdata,
  output logic        data_ack,
  output logic [7:0]  data_rdata,
  output logic        data_err,
  output logic        read_memory,
  output logic        write_memory,
  output logic [15:0] address_in,
  inout  wire  [7:0]  internal_data_bus,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

  arb_state_t state;
  arb_grant_t grant_q;
  arb_grant_t last_grant;
  arb_grant_t grant_next;
  logic       grant_valid;
  logic       trap_hit;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       count_zero;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_next  = GRANT_FETCH;
    if (fetch_req && data_req) begin
      grant_next = (last_grant == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
    end else if (data_req) begin
      grant_next = GRANT_DATA;
    end
  end

`ifdef MEMORY_ARBITER_ROM_TRAP_EN
  assign trap_hit = (grant_next == GRANT_DATA) && data_we && (data_addr < ROM_LIMIT);
`else
  assign trap_hit = 1'b0;
`endif

  arb_wait_counter #(.WIDTH(4)) u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       ((state == ARB_IDLE) && grant_valid),
    .load_value (WAIT_LOAD),
    .decrement  (state == ARB_ACCESS),
    .count_zero (count_zero)
  );

  // Write data reaches the bus only from registers, so the drive tracks the registered strobe.
  assign internal_data_bus = write_memory ? wdata_q : 8'hzz;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant_q      <= GRANT_FETCH;
      last_grant   <= GRANT_FETCH;
      we_q         <= 1'b0;
      wdata_q      <= 8'h00;
      read_memory  <= 1'b0;
      write_memory <= 1'b0;
      address_in   <= 16'h0000;
      fetch_ack    <= 1'b0;
      fetch_data   <= 8'h00;
      data_ack     <= 1'b0;
      data_rdata   <= 8'h00;
      data_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      data_err  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            grant_q    <= grant_next;
            address_in <= (grant_next == GRANT_DATA) ? data_addr : fetch_addr;
            we_q       <= (grant_next == GRANT_DATA) && data_we;
            wdata_q    <= data_wdata;
            busy       <= 1'b1;
            if (trap_hit) begin
              state    <= ARB_DONE;
              data_ack <= 1'b1;
              data_err <= 1'b1;
            end else begin
              state        <= ARB_ACCESS;
              read_memory  <= !((grant_next == GRANT_DATA) && data_we);
              write_memory <= (grant_next == GRANT_DATA) && data_we;
            end
          end
        end
        ARB_ACCESS: begin
          if (count_zero) begin
            state        <= ARB_DONE;
            read_memory  <= 1'b0;
            write_memory <= 1'b0;
            if (grant_q == GRANT_FETCH) begin
              fetch_ack <= 1'b1;
              if (!we_q) fetch_data <= internal_data_bus;
            end else begin
              data_ack <= 1'b1;
              if (!we_q) data_rdata <= internal_data_bus;
            end
          end
        end
        ARB_DONE: begin
          last_grant <= grant_q;
          state      <= ARB_IDLE;
          busy       <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with ACCESS_CYCLES=2.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_ack;
  logic [7:0]  data_rdata;
  logic        data_err;
  logic        read_memory;
  logic        write_memory;
  logic [15:0] address_in;
  wire  [7:0]  internal_data_bus;
  logic        busy;
  logic [7:0]  tb_bus;

  int checks = 0;
  int errors = 0;

  // Memory model: answers reads only while the arbiter strobes read_memory.
  assign internal_data_bus = read_memory ? tb_bus : 8'hzz;

  always #5 clock = ~clock;

  memory_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_req         (fetch_req),
    .fetch_addr        (fetch_addr),
    .fetch_ack         (fetch_ack),
    .fetch_data        (fetch_data),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_ack          (data_ack),
    .data_rdata        (data_rdata),
    .data_err          (data_err),
    .read_memory       (read_memory),
    .write_memory      (write_memory),
    .address_in        (address_in),
    .internal_data_bus (internal_data_bus),
    .busy              (busy)
  );

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = 16'h0; data_addr = 16'h0; data_wdata = 8'h0; tb_bus = 8'h0;
    tick(); tick();
    checks++; if ({read_memory, write_memory} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {read_memory, write_memory}); end
    checks++; if ({fetch_ack, data_ack, data_err, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {fetch_ack, data_ack, data_err, busy}); end
    checks++; if ({address_in, fetch_data, data_rdata} !== 32'h0) begin errors++; $display("FAIL reset_regs got %h want 0", {address_in, fetch_data, data_rdata}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    fetch_req = 1'b1; fetch_addr = 16'h1FFF; tb_bus = 8'hA5;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        checks++; if ({read_memory, write_memory} !== 2'b10) begin errors++; $display("FAIL fetch_strobe c%0d got %b want 10", c, {read_memory, write_memory}); end
        checks++; if (address_in !== 16'h1FFF) begin errors++; $display("FAIL fetch_addr c%0d got %h want 1fff", c, address_in); end
      end
      if (c == 3) begin
        checks++; if ({fetch_ack, read_memory} !== 2'b10) begin errors++; $display("FAIL fetch_ack c3 got %b want 10", {fetch_ack, read_memory}); end
        checks++; if (fetch_data !== 8'hA5) begin errors++; $display("FAIL fetch_data got %h want a5", fetch_data); end
        fetch_req = 1'b0;
      end
      if (c == 4) begin
        checks++; if ({fetch_ack, busy} !== 2'b00) begin errors++; $display("FAIL fetch_idle c4 got %b want 00", {fetch_ack, busy}); end
      end
    end
  endtask

  task automatic test_data_write_ram();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h2000; data_wdata = 8'h3C;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        checks++; if ({read_memory, write_memory} !== 2'b01) begin errors++; $display("FAIL wr_strobe c%0d got %b want 01", c, {read_memory, write_memory}); end
        checks++; if (internal_data_bus !== 8'h3C) begin errors++; $display("FAIL wr_bus c%0d got %h want 3c", c, internal_data_bus); end
      end
      if (c == 3) begin
        checks++; if (internal_data_bus === 8'h3C || write_memory !== 1'b0) begin errors++; $display("FAIL wr_release c3 got bus %h we %b want released", internal_data_bus, write_memory); end
        checks++; if ({data_ack, data_err, fetch_ack} !== 3'b100) begin errors++; $display("FAIL wr_ack c3 got %b want 100", {data_ack, data_err, fetch_ack}); end
        data_req = 1'b0; data_we = 1'b0;
      end
    end
  endtask

  task automatic test_data_read();
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h4000; tb_bus = 8'h5A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) begin
        checks++; if ({data_ack, data_rdata} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rd_data got ack %b data %h want 1 5a", data_ack, data_rdata); end
        checks++; if (fetch_data !== 8'hA5) begin errors++; $display("FAIL rd_fetch_hold got %h want a5", fetch_data); end
        data_req = 1'b0;
      end
    end
  endtask

  task automatic test_rom_trap();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h1FFE; data_wdata = 8'h77;
`ifdef MEMORY_ARBITER_ROM_TRAP_EN
    tick();
    checks++; if ({read_memory, write_memory} !== 2'b00) begin errors++; $display("FAIL trap_strobe got %b want 00", {read_memory, write_memory}); end
    checks++; if ({data_ack, data_err} !== 2'b11) begin errors++; $display("FAIL trap_ack got %b want 11", {data_ack, data_err}); end
    data_req = 1'b0; data_we = 1'b0;
    tick();
    checks++; if ({data_ack, data_err, busy} !== 3'b000) begin errors++; $display("FAIL trap_after got %b want 000", {data_ack, data_err, busy}); end
    tick();
`else
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        checks++; if (write_memory !== 1'b1) begin errors++; $display("FAIL romwr_strobe c%0d got %b want 1", c, write_memory); end
      end
      if (c == 3) begin
        checks++; if ({data_ack, data_err} !== 2'b10) begin errors++; $display("FAIL romwr_ack got %b want 10", {data_ack, data_err}); end
        data_req = 1'b0; data_we = 1'b0;
      end
    end
`endif
  endtask

  task automatic test_tie_fairness();
    int ack_cycle [3];
    bit ack_data [3];
    int n = 0;
    reset = 1'b1; fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    fetch_addr = 16'h0010; data_addr = 16'h3000; tb_bus = 8'h11;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++; if (read_memory && write_memory) begin errors++; $display("FAIL tie_overlap c%0d got 11 want not both", c); end
      if ((fetch_ack || data_ack) && n < 3) begin
        ack_cycle[n] = c; ack_data[n] = data_ack; n++;
      end
      if (c == 4 || c == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_turnaround c%0d got busy %b want 0", c, busy); end
      end
      if (c == 12) begin fetch_req = 1'b0; data_req = 1'b0; end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL tie_count got %0d want 3", n); end
    else begin
      checks++; if ({ack_data[0], ack_data[1], ack_data[2]} !== 3'b101) begin errors++; $display("FAIL tie_order got %b want 101 (data,fetch,data)", {ack_data[0], ack_data[1], ack_data[2]}); end
      checks++; if (ack_cycle[0] != 3 || ack_cycle[1] != 7 || ack_cycle[2] != 11) begin errors++; $display("FAIL tie_timing got %0d %0d %0d want 3 7 11", ack_cycle[0], ack_cycle[1], ack_cycle[2]); end
    end
    tick(); tick();
  endtask

  task automatic test_late_request();
    int data_c = 0;
    int fetch_c = 0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h3000; data_wdata = 8'h44; tb_bus = 8'h99;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin fetch_req = 1'b1; fetch_addr = 16'h0042; end
      if (data_ack && data_c == 0) begin data_c = c; data_req = 1'b0; data_we = 1'b0; end
      if (fetch_ack && fetch_c == 0) begin fetch_c = c; fetch_req = 1'b0; end
    end
    checks++; if (data_c != 3) begin errors++; $display("FAIL late_data_ack got %0d want 3", data_c); end
    checks++; if (fetch_c - data_c != 4) begin errors++; $display("FAIL late_fetch_gap got %0d want 4", fetch_c - data_c); end
    checks++; if (fetch_data !== 8'h99) begin errors++; $display("FAIL late_fetch_data got %h want 99", fetch_data); end
  endtask

  task automatic test_reset_mid_access();
    bit saw_ack = 1'b0;
    fetch_req = 1'b1; fetch_addr = 16'h0100; tb_bus = 8'hEE;
    tick();
    checks++; if (read_memory !== 1'b1) begin errors++; $display("FAIL rstmid_start got %b want 1", read_memory); end
    reset = 1'b1; fetch_req = 1'b0;
    tick();
    checks++; if ({read_memory, write_memory, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes got %b want 000", {read_memory, write_memory, busy}); end
    checks++; if (fetch_data !== 8'h00) begin errors++; $display("FAIL rstmid_fetch_data got %h want 00", fetch_data); end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (fetch_ack || data_ack) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack got %b want 0", saw_ack); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write_ram();
    test_data_read();
    test_rom_trap();
    test_tie_fairness();
    test_late_request();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
